// File: rtl/img_pixel_capture_if.sv
// img_pixel_capture_if: pixel word write bus from the capture stage to the RAM writer
interface img_pixel_capture_if;
  logic        w_valid;
  logic [15:0] w_data;
  logic        w_ready;
  modport master (output w_valid, output w_data, input w_ready);
  modport slave (input w_valid, input w_data, output w_ready);
endinterface

// File: rtl/img_pixel_capture.sv
// img_pixel_capture: frame-aligned sensor pixel capture into 16-bit words with per-frame statistics
module img_pixel_capture #(
  parameter int          PixelCountWidth    = 24,
  parameter int          LineCountWidth     = 12,
  parameter logic [11:0] HighlightThreshold = 12'hFC0,
  parameter logic [11:0] ShadowThreshold    = 12'h03F
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       img_fv,
  input  logic                       img_lv,
  input  logic [11:0]                img_d,
  input  logic                       trigger,
  input  logic [1:0]                 skip_frames,
  input  logic [PixelCountWidth-1:0] max_pixels,
  output logic                       busy,
  output logic                       done,
  img_pixel_capture_if.master        wr,
  output logic [PixelCountWidth-1:0] stat_pixel_count,
  output logic [LineCountWidth-1:0]  stat_line_count,
  output logic [PixelCountWidth-1:0] stat_highlight_count,
  output logic [PixelCountWidth-1:0] stat_shadow_count,
  output logic [31:0]                stat_checksum,
  output logic                       stat_overflow,
  output logic                       stat_truncated
);
  localparam int PW = PixelCountWidth;
  localparam int LW = LineCountWidth;
  typedef enum logic [2:0] {IDLE, WAIT_FV_LOW, WAIT_FV_HIGH, SKIP, CAPTURE, DONE} state_t;
  state_t        state_q, state_d;
  logic          fv_q, fv_d, lv_q, lv_d, fvp_q, fvp_d, lvp_q, lvp_d;
  logic [11:0]   pix_q, pix_d, wd_q, wd_d;
  logic [1:0]    skip_q, skip_d;
  logic [PW-1:0] max_q, max_d, cnt_q, cnt_d, hi_q, hi_d, sh_q, sh_d;
  logic [LW-1:0] lines_q, lines_d;
  logic [31:0]   ck_q, ck_d;
  logic          wv_q, wv_d, ovf_q, ovf_d, trunc_q, trunc_d;
  logic          fv_rise, fv_fall, cap, eligible;
  always_comb begin
    state_d  = state_q;
    fv_d     = img_fv;
    lv_d     = img_lv;
    pix_d    = img_d;
    fvp_d    = fv_q;
    lvp_d    = lv_q;
    skip_d   = skip_q;
    max_d    = max_q;
    wv_d     = 1'b0;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    lines_d  = lines_q;
    hi_d     = hi_q;
    sh_d     = sh_q;
    ck_d     = ck_q;
    ovf_d    = ovf_q | (wv_q & ~wr.w_ready);
    trunc_d  = trunc_q;
    fv_rise  = fv_q & ~fvp_q;
    fv_fall  = ~fv_q & fvp_q;
    // the frame-start cycle itself is captured, so capture is live one cycle before CAPTURE
    cap      = (state_q == CAPTURE) | ((state_q == WAIT_FV_HIGH) & fv_rise & (skip_q == 2'd0));
    eligible = cap & fv_q & lv_q;
    case (state_q)
      IDLE: if (trigger) begin
        state_d = WAIT_FV_LOW;
        skip_d  = skip_frames;
        max_d   = max_pixels;
        cnt_d   = '0;
        lines_d = '0;
        hi_d    = '0;
        sh_d    = '0;
        ck_d    = '0;
        ovf_d   = 1'b0;
        trunc_d = 1'b0;
      end
      WAIT_FV_LOW:  state_d = fv_q ? WAIT_FV_LOW : WAIT_FV_HIGH;
      WAIT_FV_HIGH: if (fv_rise) begin
        state_d = (skip_q == 2'd0) ? CAPTURE : SKIP;
        skip_d  = (skip_q == 2'd0) ? skip_q : skip_q - 2'd1;
      end
      SKIP:    state_d = fv_fall ? WAIT_FV_HIGH : SKIP;
      CAPTURE: state_d = fv_fall ? DONE : CAPTURE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (eligible & ~lvp_q)
      lines_d = (lines_q == '1) ? lines_q : lines_q + LW'(1);
    if (eligible & ((max_q == '0) | (cnt_q < max_q))) begin
      wv_d  = 1'b1;
      wd_d  = pix_q;
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + PW'(1);
      ck_d  = ck_q + 32'(pix_q);
      hi_d  = ((pix_q >= HighlightThreshold) & (hi_q != '1)) ? hi_q + PW'(1) : hi_q;
      sh_d  = ((pix_q <= ShadowThreshold) & (sh_q != '1)) ? sh_q + PW'(1) : sh_q;
    end else if (eligible) begin
      trunc_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      pix_q   <= '0;
      fvp_q   <= 1'b1;
      lvp_q   <= 1'b0;
      skip_q  <= '0;
      max_q   <= '0;
      wv_q    <= 1'b0;
      wd_q    <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      hi_q    <= '0;
      sh_q    <= '0;
      ck_q    <= '0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      pix_q   <= pix_d;
      fvp_q   <= fvp_d;
      lvp_q   <= lvp_d;
      skip_q  <= skip_d;
      max_q   <= max_d;
      wv_q    <= wv_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      hi_q    <= hi_d;
      sh_q    <= sh_d;
      ck_q    <= ck_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
    end
  end
  assign busy                 = (state_q != IDLE) & (state_q != DONE);
  assign done                 = state_q == DONE;
  assign wr.w_valid           = wv_q;
  assign wr.w_data            = {4'b0, wd_q};
  assign stat_pixel_count     = cnt_q;
  assign stat_line_count      = lines_q;
  assign stat_highlight_count = hi_q;
  assign stat_shadow_count    = sh_q;
  assign stat_checksum        = ck_q;
  assign stat_overflow        = ovf_q;
  assign stat_truncated       = trunc_q;
endmodule

// File: doc/img_pixel_capture.md
Name: img_pixel_capture

Overview:
- Front-end capture stage between the image sensor parallel port and the RAM write path.
- Aligns to a complete frame on command, skips a programmable number of frames, then streams each valid pixel as a 16-bit word to the RAM writer.
- Accumulates per-frame statistics (pixel/line counts, highlight/shadow counts, checksum) that the STM reads back over SPI after capture.
- Runs entirely in the sensor pixel-clock domain; the RAM writer and the SPI readout consume its outputs.

Parameters:
- PixelCountWidth, 24, width of the pixel-count, max_pixels and highlight/shadow counters.
- LineCountWidth, 12, width of the line counter.
- HighlightThreshold, 12'hFC0, a pixel >= this value counts as a highlight.
- ShadowThreshold, 12'h03F, a pixel <= this value counts as a shadow.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge. The single clock of the block.
- rst_  in  1  asynchronous active-low reset.
- img_fv  in  1  sensor frame-valid, synchronous to clk.
- img_lv  in  1  sensor line-valid, synchronous to clk.
- img_d  in  12  sensor pixel data.
- trigger  in  1  single-cycle capture request.
- skip_frames  in  2  number of whole frames to discard before capturing; sampled on trigger accept.
- max_pixels  in  PixelCountWidth  maximum number of words written; 0 means unlimited. Sampled on trigger accept.
- busy  out  1  high from trigger accept until done.
- done  out  1  one-cycle pulse at end of capture.
- w_valid  out  1  pixel word valid.
- w_data  out  16  {4'b0, pixel}.
- w_ready  in  1  RAM writer can accept; no stall possible, used for overflow detection only.
- stat_pixel_count  out  PixelCountWidth  words written.
- stat_line_count  out  LineCountWidth  lines seen in the captured frame.
- stat_highlight_count  out  PixelCountWidth  highlight pixels.
- stat_shadow_count  out  PixelCountWidth  shadow pixels.
- stat_checksum  out  32  running sum of w_data, mod 2^32.
- stat_overflow  out  1  sticky: w_valid was high while w_ready was low.
- stat_truncated  out  1  sticky: pixels were dropped because max_pixels was reached.

Behaviour:
- Reset (async assert, sync release): every output is 0; the state machine goes to IDLE.
- Input stage: img_fv, img_lv and img_d are registered once (stage r1). All decisions use r1 values.
- Edges: fv_rise = r1 fv && !prev fv; fv_fall = !r1 fv && prev fv. prev is reset to 1, so a frame already in progress at reset is never treated as a new frame.
- State IDLE:
  - trigger -> WAIT_FV_LOW.
  - On accept: clear all stat_* and sticky flags, latch skip_frames and max_pixels, set busy=1.
- State WAIT_FV_LOW: when r1 fv==0 -> WAIT_FV_HIGH. This guarantees no partial frame is captured.
- State WAIT_FV_HIGH:
  - On fv_rise with skip counter > 0: decrement the counter -> SKIP.
  - On fv_rise with skip counter == 0: go to CAPTURE. The rising-edge pixel itself is captured if r1 lv==1.
- State SKIP: on fv_fall -> WAIT_FV_HIGH.
- State CAPTURE:
  - Each cycle with r1 fv && r1 lv: the pixel is eligible.
  - If max_pixels==0 or stat_pixel_count < max_pixels:
    - the next cycle drives w_valid=1 and w_data={4'b0, r1 d};
    - stat_pixel_count increments and stat_checksum += w_data;
    - stat_highlight_count or stat_shadow_count increments per threshold (both, if the thresholds overlap).
  - Otherwise set stat_truncated; no write, no stat update.
  - stat_line_count increments on each rising edge of r1 lv while r1 fv is high.
  - lv while fv is low is ignored.
  - On fv_fall -> DONE.
- State DONE: done=1 for exactly one cycle, busy=0, then -> IDLE. Stats hold until the next trigger accept.
- Latency: a pixel on img_d at edge k appears on w_data/w_valid after edge k+2 (2 cycles). Stats update on the same edge as w_valid.
- w_valid is high at most one cycle per pixel. If w_ready==0 during a w_valid cycle, set stat_overflow; the word is still counted.
- trigger while busy is ignored.
- Counters saturate at all-ones (no wrap). stat_checksum wraps mod 2^32.
- Reset mid-capture: immediate return to IDLE, all outputs 0. The next trigger waits for fv low.

Test Plan:
- Basic frame: trigger, skip=0, max=0, then a 4-pixel x 3-line frame with d=line*16+col -> 12 w_valid pulses, pixel 0 at 2-cycle latency, pixel_count=12, line_count=3, checksum=0+1+2+3+16+17+18+19+32+33+34+35=210, one done pulse, busy low after.
- Mid-frame trigger: trigger while fv is already high -> no writes in the current frame; capture starts on the next fv_rise.
- Skip frames: skip=2 with three back-to-back frames -> only frame 3 is written; stat_line_count reflects frame 3 only.
- Truncation: max=5 on a 12-pixel frame -> exactly 5 w_valid, pixel_count=5, truncated=1, done at fv_fall.
- Overflow and thresholds: pixels {0xFFF, 0x000, 0x800} with w_ready low on the 2nd word -> highlight=1, shadow=1, overflow=1, pixel_count=3.
- Reset mid-capture: assert rst_ after 6 pixels -> all outputs 0 immediately; a new trigger captures the next full frame with correct stats.
